// File: rtl/pulse_tracer_pkg.sv
// Shared constants and helpers for the pulse_tracer glitch filter.
package pulse_tracer_pkg;

    localparam int PULSE_TRACER_FILTER_LEN_DEFAULT = 3;
    localparam int PULSE_TRACER_FILTER_LEN_MAX     = 255;

    // Width needed to hold run counts 0..filter_len inclusive.
    function automatic int cnt_width(input int filter_len);
        int w;
        w = 1;
        while ((1 << w) < (filter_len + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pulse_tracer_sync.sv
// Two-flop metastability synchronizer with synchronous active-low reset.
module pulse_tracer_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_reg;

    // Shift the raw level through two flops before anyone looks at it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], din};
        end
    end

    assign dout = sync_reg[1];

endmodule

// File: rtl/pulse_tracer.sv
// Glitch-filtering rising-edge detector: one registered pulse after
// FILTER_LEN consecutive high samples, no retrigger while held high.
// Optional feature: define PULSE_TRACER_SYNC_EN to put a 2-flop
// synchronizer in front of the filter (adds 2 cycles of latency).
module pulse_tracer
    import pulse_tracer_pkg::*;
#(
    parameter int FILTER_LEN = PULSE_TRACER_FILTER_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy_in,
    output logic pulse_out
);

    localparam int            CW     = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0] LEN_C  = CW'(FILTER_LEN);
    localparam logic [CW-1:0] LAST_C = CW'(FILTER_LEN - 1);

    if (FILTER_LEN < 1 || FILTER_LEN > PULSE_TRACER_FILTER_LEN_MAX) begin : g_len_check
        $error("pulse_tracer: FILTER_LEN=%0d outside 1..%0d",
               FILTER_LEN, PULSE_TRACER_FILTER_LEN_MAX);
    end

    logic          sample;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          pulse_reg;
    logic          pulse_next;

`ifdef PULSE_TRACER_SYNC_EN
    pulse_tracer_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (noisy_in),
        .dout  (sample)
    );
`else
    // Input is assumed already synchronous to clk.
    assign sample = noisy_in;
`endif

    // Run counter: any low restarts, saturate at FILTER_LEN so a held
    // high level pulses only once on the qualifying sample.
    always_comb begin
        cnt_next   = '0;
        pulse_next = 1'b0;
        if (sample) begin
            if (cnt_reg < LEN_C) begin
                cnt_next   = cnt_reg + CW'(1);
                pulse_next = (cnt_reg == LAST_C);
            end else begin
                cnt_next   = cnt_reg;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            pulse_reg <= pulse_next;
        end
    end

    assign pulse_out = pulse_reg;

endmodule

// File: tb/tb_pulse_tracer.sv
// Scoreboard bench for pulse_tracer: driver pushes expected pulse_out per
// edge from a run-length reference model, monitor pops and compares.
module tb_pulse_tracer;

    localparam int FL = 3;

    logic clk;
    logic rst_n;
    logic noisy_in;
    logic pulse_out;

    pulse_tracer #(.FILTER_LEN(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .noisy_in  (noisy_in),
        .pulse_out (pulse_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit exp_q[$];
    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int exp_pulses = 0;
    int obs_pulses = 0;
    bit done       = 0;

    // Reference model state: length of the current run of high samples
    // since the last low or reset (unbounded), plus sync pipeline.
    int run = 0;
    bit sq0 = 0;
    bit sq1 = 0;

    // Drive one cycle of inputs and queue the pulse_out expected after
    // the following rising edge.
    task automatic step(input bit rst, input bit din);
        bit s;
        bit e;
        @(negedge clk);
        rst_n    = ~rst;
        noisy_in = din;
        if (rst) begin
            run = 0;
            sq0 = 0;
            sq1 = 0;
            e   = 0;
        end else begin
`ifdef PULSE_TRACER_SYNC_EN
            s   = sq1;
            sq1 = sq0;
            sq0 = din;
`else
            s   = din;
`endif
            run = s ? run + 1 : 0;
            e   = (run == FL);
        end
        if (e) exp_pulses++;
        exp_q.push_back(e);
    endtask

    task automatic hold(input bit din, input int n);
        for (int i = 0; i < n; i++) step(0, din);
    endtask

    task automatic pattern(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(0, bits[i]);
    endtask

    // Monitor: compare every cycle's pulse_out against the scoreboard.
    initial begin
        bit e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pulse_out === 1'b1) obs_pulses++;
                if (pulse_out !== e) begin
                    errors++;
                    $display("FAIL pulse_cycle t=%0t cyc=%0d: pulse_out=%b expected=%b",
                             $time, cyc, pulse_out, e);
                end else if (e) begin
                    $display("pulse ok t=%0t cyc=%0d", $time, cyc);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized runs with resets.
    initial begin
        int v;
        int len;
        rst_n    = 1'b0;
        noisy_in = 1'b0;

        step(1, 0); step(1, 0);
        hold(1, 1); hold(0, 5);

        hold(1, 4); hold(0, 3);

        pattern(16'b0000_0010_1101_1010, 10);
        hold(1, 4); hold(0, 3); hold(1, 4); hold(0, 3);

        hold(1, 13); hold(0, 1);
        pattern(16'b0000_0000_0001_0111, 5);
        hold(0, 2);

        hold(1, 2); step(1, 1); hold(1, 5); hold(0, 2);

        step(1, 0);
        for (int i = 0; i < 600; i++) begin
            v   = $urandom_range(0, 1);
            len = $urandom_range(1, 6);
            if ($urandom_range(0, 49) == 0) begin
                step(1, v[0]);
            end else begin
                hold(v[0], len);
            end
        end
        hold(0, 4);
        done = 1;
    end

    // Final checks and summary, with a hard time limit.
    initial begin
        fork
            begin
                wait (done);
                repeat (3) @(posedge clk);
                #2;
            end
            begin
                #400000;
                checks++;
                errors++;
                $display("FAIL timeout: driver_done=%0b required=1", done);
            end
        join_any
        disable fork;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        checks++;
        if (obs_pulses != exp_pulses) begin
            errors++;
            $display("FAIL pulse_total: observed=%0d expected=%0d", obs_pulses, exp_pulses);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_tracer.md
# pulse_tracer

Glitch-filtering rising-edge detector for a noisy, single-bit input. It emits exactly one single-cycle `pulse_out` when `noisy_in` has been sampled high for `FILTER_LEN` consecutive clock cycles. Any low sample discards the partial qualification, and a long-held high level produces only that one pulse. It sits between raw external inputs (buttons, sensor lines, slow strobes) and synchronous control logic that needs a clean one-shot event.

## Interface
- `FILTER_LEN`, default 3: number of consecutive high samples required to qualify a pulse; legal range 1..255.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `noisy_in` input 1: raw input level; may glitch on any cycle.
- `pulse_out` output 1: registered one-cycle qualified-rise pulse.

## Operation
- Internal state:
  - run counter `cnt`, width `$clog2(FILTER_LEN+1)`, saturating at `FILTER_LEN`;
  - registered `pulse_out`.
- Sampled input `s` is `noisy_in`, or the synchronizer output when `PULSE_TRACER_SYNC_EN` is defined.
- Each rising edge with `rst_n`=1:
  - `s`=1 and `cnt`<`FILTER_LEN`: `cnt` increments; `pulse_out` <= (`cnt` == `FILTER_LEN`-1).
  - `s`=1 and `cnt`==`FILTER_LEN`: `cnt` holds (saturated); `pulse_out` <= 0.
  - `s`=0: `cnt` <= 0; `pulse_out` <= 0.
- A single low sample fully restarts qualification. There is no hysteresis on release; low is accepted immediately.
- After saturation, no further pulse occurs until at least one low sample, then `FILTER_LEN` new consecutive highs.
- `FILTER_LEN`=1: pulse on the first high sample following any low sample or reset.
- Input held high through reset release counts as a new rise; pulse after `FILTER_LEN` post-reset samples.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `cnt`=0, `pulse_out`=0, synchronizer flops=0.
  - Takes effect mid-qualification or mid-pulse; partial counts are lost.
- Latency with macro off: `pulse_out` rises at the edge that samples the `FILTER_LEN`-th consecutive high, i.e. `FILTER_LEN` edges after the first high sample.
- With `PULSE_TRACER_SYNC_EN`: add 2 cycles.
- `pulse_out` width is exactly 1 cycle and is never asserted on two consecutive cycles.
- Minimum spacing between pulses is `FILTER_LEN`+1 cycles: at least one low sample plus `FILTER_LEN` highs.
- No combinational path from `noisy_in` to `pulse_out`.

## Configuration
- `PULSE_TRACER_SYNC_EN` defined:
  - `noisy_in` passes through a 2-flop metastability synchronizer before filtering.
  - All timing shifts by +2 cycles; filtering rules unchanged.
- Undefined:
  - `noisy_in` is sampled directly; the input is assumed synchronous to `clk`.

## Structure
- Package `pulse_tracer_pkg`:
  - constant `PULSE_TRACER_FILTER_LEN_DEFAULT` = 3;
  - constant `PULSE_TRACER_FILTER_LEN_MAX` = 255;
  - function computing counter width from `FILTER_LEN`.
- One sub-module, `pulse_tracer_sync`: 2-flop synchronizer with synchronous active-low reset, instantiated only under `PULSE_TRACER_SYNC_EN`.
- Elaboration-time check: `FILTER_LEN` within 1..255, else `$error`.

## Test plan
All scenarios use `FILTER_LEN`=3 and macro off unless stated.
- Reset 2 cycles with `noisy_in`=0, then a 1-cycle high glitch followed by 5 lows -> `pulse_out` stays 0 throughout.
- `noisy_in` high for 4 cycles then low for 3 -> exactly one `pulse_out` cycle, at the 3rd high sample edge.
- Pattern 1,0,1,1,0,1,1,0,1,0 -> no pulse; then two high bursts of 4 separated by 3 lows -> exactly two pulses, 7 cycles apart.
- `noisy_in` high for 13 cycles -> single pulse at the 3rd sample, none after; pattern 1,0,1,1,1 -> single pulse at the last sample.
- Reset asserted after 2 high samples with input still high, released next cycle -> pulse 3 edges after release, never earlier.
- `PULSE_TRACER_SYNC_EN` defined, `FILTER_LEN`=1, single high cycle -> one pulse exactly 3 edges after that sample.
